// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared definitions for the arithmetic library
//                (state encoding for the sequential divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

   // Divider controller states
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Width of a down-counter that must hold the value n
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_cell.sv
`default_nettype none
// ============================================================================
//  Module      : div_cell
//  Description : Combinational restoring-division stage. Shifts the next
//                dividend bit into the partial remainder, trial-subtracts the
//                divisor and keeps the difference only when no borrow occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_cell #(
   parameter int WS = 4
) (
   input  logic [WS:0]   pr_in,
   input  logic          bit_in,
   input  logic [WS-1:0] d,
   output logic [WS:0]   pr_out,
   output logic          qbit
);

   logic [WS:0]   w_t;
   logic [WS:0]   w_nd;
   logic [WS:0]   w_diff;
   logic [WS+1:0] w_c;

   // Shifted partial remainder and inverted divisor for t + ~d + 1
   assign w_t    = {pr_in[WS-1:0], bit_in};
   assign w_nd   = ~{1'b0, d};
   assign w_c[0] = 1'b1;

   // Ripple-borrow subtractor; carry-out high means no borrow
   generate
      for (genvar i = 0; i <= WS; i++) begin : g_sub
         fa u_fa (
            .a  (w_t[i]),
            .b  (w_nd[i]),
            .ci (w_c[i]),
            .s  (w_diff[i]),
            .co (w_c[i+1])
         );
      end
   endgenerate

   // A set top bit of pr_in means the true shifted value already exceeds any
   // divisor, so the subtraction must succeed; the low bits of w_diff stay
   // correct modulo 2^(WS+1).
   assign qbit   = w_c[WS+1] | pr_in[WS];
   assign pr_out = qbit ? w_diff : w_t;

endmodule
`default_nettype wire

// File: rtl/fa.sv
`default_nettype none
// ============================================================================
//  Module      : fa
//  Description : One-bit full adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Sequential restoring divider, one quotient bit per clock.
//                WD-bit dividend / WS-bit divisor -> WD-bit quotient and
//                WS-bit remainder, with start/busy/done handshake and a
//                divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
   import arith_pkg::*;
#(
   parameter int WD = 8,
   parameter int WS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [WD-1:0] x,
   input  logic [WS-1:0] y,
   output logic [WD-1:0] q,
   output logic [WS-1:0] r,
   output logic          busy,
   output logic          done,
   output logic          dbz
);

   localparam int             CW         = cnt_width(WD);
   localparam logic [CW-1:0]  c_cnt_load = CW'(WD);
   localparam logic [CW-1:0]  c_cnt_last = CW'(1);

   logic [1:0]    r_state;
   logic [WD-1:0] r_dvd;
   logic [WS-1:0] r_dvs;
   logic [WS:0]   r_pr;
   logic [CW-1:0] r_cnt;
   logic [WD-1:0] r_q;
   logic [WS-1:0] r_r;
   logic          r_dbz;

   logic          w_accept;
   logic [WS:0]   w_pr_next;
   logic          w_qbit;

   // A request is taken in IDLE and DONE, never while a division runs
   assign w_accept = start & (r_state != S_RUN);

   div_cell #(.WS(WS)) u_cell (
      .pr_in  (r_pr),
      .bit_in (r_dvd[WD-1]),
      .d      (r_dvs),
      .pr_out (w_pr_next),
      .qbit   (w_qbit)
   );

   // Controller and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_pr    <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               r_pr  <= w_pr_next;
               r_dvd <= {r_dvd[WD-2:0], w_qbit};
               r_cnt <= r_cnt - c_cnt_last;
               if (r_cnt == c_cnt_last) begin
                  r_q     <= {r_dvd[WD-2:0], w_qbit};
                  r_r     <= w_pr_next[WS-1:0];
                  r_state <= S_DONE;
               end
            end
            default: begin
               if (w_accept) begin
                  if (y == '0) begin
                     // Divide by zero finishes immediately with a saturated quotient
                     r_q     <= '1;
                     r_r     <= '0;
                     r_dbz   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_dvd   <= x;
                     r_dvs   <= y;
                     r_pr    <= '0;
                     r_cnt   <= c_cnt_load;
                     r_dbz   <= 1'b0;
                     r_state <= S_RUN;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign q    = r_q;
   assign r    = r_r;
   assign dbz  = r_dbz;
   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Scoreboard testbench for div_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] x = '0;
   logic [3:0] y = '0;
   logic [7:0] q;
   logic [3:0] r;
   logic       busy;
   logic       done;
   logic       dbz;

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       dbz;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   was_done;

   div_seq #(.WD(8), .WS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x     (x),
      .y     (y),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: pop the oldest expectation whenever a result is presented
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("q",   32'(q),   32'(e.q));
            check("r",   32'(r),   32'(e.r));
            check("dbz", 32'(dbz), 32'(e.dbz));
         end
      end
   end

   // Present one request at the first negedge where the divider is free
   task automatic issue(input logic [7:0] xi, input logic [3:0] yi, input bit exp_res,
                        input logic [7:0] eq, input logic [3:0] er, input bit ed);
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("issue_timeout", 32'(busy), 32'd0);
      was_done = done;
      start = 1'b1;
      x = xi;
      y = yi;
      if (exp_res) sb.push_back('{eq, er, ed});
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy || done) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Count busy cycles until done appears; n_cyc is negedges before done
   task automatic measure(output int bc, output int n_cyc);
      bc = 0;
      n_cyc = 0;
      @(negedge clk);
      while (!done && n_cyc < 30) begin
         if (busy) bc++;
         n_cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, nc;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_q",    32'(q),    32'd0);
      check("rst_r",    32'(r),    32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dbz",  32'(dbz),  32'd0);
      rst_n = 1'b1;

      // Basic division with latency and busy-length checks
      issue(8'd200, 4'd13, 1'b1, 8'd15, 4'd5, 1'b0);
      measure(bc, nc);
      check("busy_cycles", 32'(bc), 32'd8);
      check("done_latency", 32'(nc), 32'd8);
      @(negedge clk);
      check("done_pulse_width", 32'(done), 32'd0);
      check("q_hold", 32'(q), 32'd15);

      // Divide by zero: one-cycle latency, busy never high
      issue(8'd100, 4'd0, 1'b1, 8'hFF, 4'd0, 1'b1);
      measure(bc, nc);
      check("dbz_busy_cycles", 32'(bc), 32'd0);
      check("dbz_latency", 32'(nc), 32'd0);
      wait_idle();

      // Quotient-range edges and other directed vectors
      issue(8'd255, 4'd1,  1'b1, 8'd255, 4'd0,  1'b0);
      issue(8'd7,   4'd9,  1'b1, 8'd0,   4'd7,  1'b0);
      issue(8'd0,   4'd5,  1'b1, 8'd0,   4'd0,  1'b0);
      issue(8'd255, 4'd15, 1'b1, 8'd17,  4'd0,  1'b0);
      issue(8'd254, 4'd15, 1'b1, 8'd16,  4'd14, 1'b0);
      issue(8'd13,  4'd13, 1'b1, 8'd1,   4'd0,  1'b0);
      issue(8'd128, 4'd3,  1'b1, 8'd42,  4'd2,  1'b0);
      wait_idle();

      // Back-to-back: second start taken in the DONE cycle
      issue(8'd17, 4'd4, 1'b1, 8'd4, 4'd1, 1'b0);
      issue(8'd9,  4'd2, 1'b1, 8'd4, 4'd1, 1'b0);
      check("b2b_accept_in_done", 32'(was_done), 32'd1);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_idle();

      // start and operand changes during RUN are ignored
      issue(8'd200, 4'd13, 1'b1, 8'd15, 4'd5, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      x = 8'd3;
      y = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("ignored_q", 32'(q), 32'd15);
      check("ignored_r", 32'(r), 32'd5);

      // Asynchronous reset in the fourth RUN cycle
      issue(8'd99, 4'd7, 1'b0, 8'd0, 4'd0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_q",    32'(q),    32'd0);
      check("abort_r",    32'(r),    32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(8'd200, 4'd13, 1'b1, 8'd15, 4'd5, 1'b0);
      wait_idle();

      // Every dividend against every non-zero divisor
      for (int xi = 0; xi < 256; xi++) begin
         for (int yi = 1; yi < 16; yi++) begin
            issue(8'(xi), 4'(yi), 1'b1, 8'(xi / yi), 4'(xi % yi), 1'b0);
         end
      end
      wait_idle();

      // Products of the 4x4 multiplier divide back exactly
      for (int a = 0; a < 16; a++) begin
         for (int b = 1; b < 16; b++) begin
            issue(8'(a * b), 4'(b), 1'b1, 8'(a), 4'd0, 1'b0);
         end
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
